backend_redirect_gen: RTL
=========================

# backend_redirect_gen

Backend-side producer of the fetch redirect channel consumed by the IF0 PC register. Collects branch resolutions from two execute-stage branch units and selects the oldest mispredicted branch by ROB age. Holds the selected redirect until the frontend accepts it, then drops wrong-path resolutions until the pipeline flush that the mispredict triggers. One request is outstanding at a time; an older mispredict always pre-empts a younger one that has not been accepted.

## Interface
Parameters:
- ROB_IDX_W, 6, ROB index width; ages compare modulo 2^ROB_IDX_W.

Ports (clock and reset first):
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- br0_valid / br1_valid  in  1  branch unit 0/1 resolution this cycle.
- br0_mispredict / br1_mispredict  in  1  resolved direction or target differs from prediction.
- br0_robIdx / br1_robIdx  in  ROB_IDX_W  ROB index of the resolved branch.
- br0_target / br1_target  in  32  correct next PC.
- rob_head  in  ROB_IDX_W  index of the oldest in-flight ROB entry.
- flush  in  1  backend flush; clears all state.
- redirect_ready  in  1  frontend accepts the redirect (the IF0 side ties this high).
- redirect_valid  out  1  request present.
- redirect  out  1  request is a redirect; always equal to redirect_valid.
- redirect_pc  out  32  redirect target.
- squash_robIdx  out  ROB_IDX_W  ROB index of the branch currently pending or last sent; ROB/issue use it for younger-squash.

## Operation
- Age: age(x) = (x - rob_head) mod 2^ROB_IDX_W, using unsigned ROB_IDX_W-bit subtraction. Smaller age is older.
- Candidate: a channel with brN_valid && brN_mispredict. If both channels are candidates, the one with the smaller age wins. On equal age, channel 0 wins.
- States:
  - IDLE: no request.
  - PENDING: redirect_valid=1; pend_pc and pend_idx are held.
  - SENT: request accepted; waiting for flush.
- Transitions:
  - IDLE: candidate -> PENDING, loading the candidate.
  - PENDING, accepted (redirect_valid && redirect_ready):
    - With an older candidate (age < age(pend_idx)) in the same cycle -> PENDING, loading the candidate.
    - Otherwise -> SENT. pend_idx is kept as sent_idx.
  - PENDING, not accepted:
    - Older candidate -> replace the pending request.
    - Younger or equal-age candidate -> ignored.
  - SENT: candidate older than sent_idx -> PENDING with the new one. Younger or equal -> dropped as wrong path.
  - Any state: flush -> IDLE. Flush has priority over candidates arriving in the same cycle, which are discarded.
- Outputs:
  - redirect_valid = redirect = (state == PENDING).
  - redirect_pc = pend_pc.
  - squash_robIdx = pend_idx in both PENDING and SENT.
- Correctly predicted resolutions (brN_mispredict=0) never change state.

## Timing
- Reset (rst=1 at posedge):
  - state=IDLE, redirect_valid=0, redirect=0, redirect_pc=32'h0, squash_robIdx=0.
- Latency: a candidate at cycle t gives redirect_valid=1 at cycle t+1. All outputs are registered; there is no combinational path from inputs to outputs.
- Handshake: once redirect_valid is asserted, it stays asserted until accepted or flushed. redirect_pc changes only when an older candidate replaces the request.
- Acceptance at edge t moves state to SENT at t+1, so redirect_valid=0 at t+1.
- rob_head may advance during PENDING or SENT. Ages are recomputed every cycle against the current rob_head.
- rst or flush mid-request drops the request with no acceptance.

## Test plan
- Reset, then br0 mispredict with robIdx=5, target=0x8000_0100, rob_head=0, redirect_ready=1 -> next cycle valid=redirect=1, pc=0x8000_0100, squash_robIdx=5; the cycle after, valid=0 (SENT).
- Both channels mispredict in the same cycle: br0 idx=10 (pc 0xA0), br1 idx=3 (pc 0x30), head=0 -> pc=0x30, squash_robIdx=3. Repeat with head=8 -> idx 10 is older, so pc=0xA0.
- redirect_ready=0. Pending idx=7, then a mispredict idx=2 arrives -> pc switches to idx 2's target. A later idx=9 is ignored. Raise ready -> idx 2's redirect accepted once.
- Wrap-around: head=60, W=6. Mispredicts idx=62 then idx=1 -> idx 62 wins (age 2 < 5).
- SENT with sent_idx=20 and head=16: a mispredict at idx=25 is dropped (valid stays 0); a mispredict at idx=18 gives a new PENDING request.
- flush asserted together with a candidate while PENDING -> IDLE next cycle, valid=0. A candidate in the following cycle is accepted normally.

Source files
------------

// File: rtl/backend_redirect_gen.sv
// backend_redirect_gen: picks the oldest mispredicted branch from two branch
// units and holds it as a fetch redirect until the frontend accepts it. After
// acceptance it drops wrong-path (younger) resolutions until flush.
module backend_redirect_gen #(
    parameter int ROB_IDX_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 br0_valid,
    input  logic                 br0_mispredict,
    input  logic [ROB_IDX_W-1:0] br0_robIdx,
    input  logic [31:0]          br0_target,
    input  logic                 br1_valid,
    input  logic                 br1_mispredict,
    input  logic [ROB_IDX_W-1:0] br1_robIdx,
    input  logic [31:0]          br1_target,
    input  logic [ROB_IDX_W-1:0] rob_head,
    input  logic                 flush,
    input  logic                 redirect_ready,
    output logic                 redirect_valid,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [ROB_IDX_W-1:0] squash_robIdx
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_SENT    = 2'd2
    } state_e;

    typedef struct packed {
        logic                 vld;
        logic [ROB_IDX_W-1:0] idx;
        logic [ROB_IDX_W-1:0] age;
        logic [31:0]          pc;
    } cand_t;

    state_e               state_q, state_d;
    logic [31:0]          pend_pc_q, pend_pc_d;
    logic [ROB_IDX_W-1:0] pend_idx_q, pend_idx_d;

    cand_t                c0, c1, cand;
    logic [ROB_IDX_W-1:0] pend_age;
    logic                 cand_older;

    // Per-channel candidates with age measured from the current ROB head.
    always_comb begin
        c0.vld = br0_valid && br0_mispredict;
        c0.idx = br0_robIdx;
        c0.age = br0_robIdx - rob_head;
        c0.pc  = br0_target;
        c1.vld = br1_valid && br1_mispredict;
        c1.idx = br1_robIdx;
        c1.age = br1_robIdx - rob_head;
        c1.pc  = br1_target;
    end

    // Oldest candidate wins; channel 0 takes ties.
    always_comb begin
        cand = c0;
        if (c1.vld && (!c0.vld || (c1.age < c0.age))) begin
            cand = c1;
        end
        pend_age   = pend_idx_q - rob_head;
        cand_older = cand.vld && (cand.age < pend_age);
    end

    // Next-state logic: flush beats everything, older mispredicts pre-empt.
    always_comb begin
        state_d    = state_q;
        pend_pc_d  = pend_pc_q;
        pend_idx_d = pend_idx_q;
        if (flush) begin
            state_d    = ST_IDLE;
            pend_pc_d  = '0;
            pend_idx_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (cand.vld) begin
                        state_d    = ST_PENDING;
                        pend_pc_d  = cand.pc;
                        pend_idx_d = cand.idx;
                    end
                end
                ST_PENDING: begin
                    // An older candidate replaces the request even in the
                    // cycle the current one is accepted.
                    if (cand_older) begin
                        pend_pc_d  = cand.pc;
                        pend_idx_d = cand.idx;
                    end else if (redirect_ready) begin
                        state_d = ST_SENT;
                    end
                end
                ST_SENT: begin
                    if (cand_older) begin
                        state_d    = ST_PENDING;
                        pend_pc_d  = cand.pc;
                        pend_idx_d = cand.idx;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pend_pc_q  <= '0;
            pend_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_pc_q  <= pend_pc_d;
            pend_idx_q <= pend_idx_d;
        end
    end

    assign redirect_valid = (state_q == ST_PENDING);
    assign redirect       = redirect_valid;
    assign redirect_pc    = pend_pc_q;
    assign squash_robIdx  = pend_idx_q;

endmodule
